// File: rtl/updown_counter_if.sv
// Control/status bundle for updown_counter: enable, direction, clear/load in; count and strobes out.
interface updown_counter_if #(
  parameter int unsigned WIDTH = 6
);
  logic             en_i;
  logic             up_i;
  logic             clear_i;
  logic             load_i;
  logic [WIDTH-1:0] load_val_i;
  logic [WIDTH-1:0] count_o;
  logic             tick_o;
  logic             tc_o;

  modport master (
    output en_i, up_i, clear_i, load_i, load_val_i,
    input  count_o, tick_o, tc_o
  );

  modport slave (
    input  en_i, up_i, clear_i, load_i, load_val_i,
    output count_o, tick_o, tc_o
  );
endinterface

// File: rtl/updown_counter.sv
// Up/down modulo counter with prescaler, sync clear/load and registered tick/tc strobes.
// Define UPDOWN_COUNTER_SATURATE_EN to saturate at the bounds instead of wrapping.
module updown_counter #(
  parameter int unsigned WIDTH    = 6,
  parameter int unsigned MODULUS  = 64,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clock_i,
  input  logic             reset_ni,
  updown_counter_if.slave  bus
);

  localparam int unsigned      PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULUS - 1);
  localparam logic [PW-1:0]    PRE_MAX = PW'(PRESCALE - 1);

`ifdef UPDOWN_COUNTER_SATURATE_EN
  localparam bit SATURATE = 1'b1;
`else
  localparam bit SATURATE = 1'b0;
`endif

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             tick_q, tick_d;
  logic             tc_q, tc_d;
  logic             step;

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt_q  <= '0;
      pre_q  <= '0;
      tick_q <= 1'b0;
      tc_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pre_q  <= pre_d;
      tick_q <= tick_d;
      tc_q   <= tc_d;
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    pre_d  = pre_q;
    tick_d = 1'b0;
    tc_d   = 1'b0;
    step   = 1'b0;

    if (bus.clear_i) begin
      cnt_d = '0;
      pre_d = '0;
    end else if (bus.load_i) begin
      cnt_d = (bus.load_val_i <= CNT_MAX) ? bus.load_val_i : CNT_MAX;
      pre_d = '0;
    end else if (bus.en_i) begin
      if (pre_q == PRE_MAX) begin
        pre_d = '0;
        step  = 1'b1;
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end

    // Bound hits raise tc in both modes; only the landing value differs.
    if (step) begin
      tick_d = 1'b1;
      if (bus.up_i) begin
        if (cnt_q == CNT_MAX) begin
          tc_d  = 1'b1;
          cnt_d = SATURATE ? CNT_MAX : '0;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end else begin
        if (cnt_q == '0) begin
          tc_d  = 1'b1;
          cnt_d = SATURATE ? '0 : CNT_MAX;
        end else begin
          cnt_d = cnt_q - WIDTH'(1);
        end
      end
    end
  end

  assign bus.count_o = cnt_q;
  assign bus.tick_o  = tick_q;
  assign bus.tc_o    = tc_q;

endmodule

// File: tb/tb_updown_counter.sv
// Bench for updown_counter: two configurations (64/1 and 10/3) against an arithmetic reference model.
module tb_updown_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, up, clear, load;
  logic [5:0] load_val;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  updown_counter_if #(.WIDTH(6)) if_a ();
  updown_counter_if #(.WIDTH(6)) if_b ();

  assign if_a.en_i = en;    assign if_b.en_i = en;
  assign if_a.up_i = up;    assign if_b.up_i = up;
  assign if_a.clear_i = clear;  assign if_b.clear_i = clear;
  assign if_a.load_i = load;    assign if_b.load_i = load;
  assign if_a.load_val_i = load_val;  assign if_b.load_val_i = load_val;

  updown_counter #(.WIDTH(6), .MODULUS(64), .PRESCALE(1)) dut_a (
    .clock_i(clk), .reset_ni(rst_n), .bus(if_a.slave)
  );
  updown_counter #(.WIDTH(6), .MODULUS(10), .PRESCALE(3)) dut_b (
    .clock_i(clk), .reset_ni(rst_n), .bus(if_b.slave)
  );

`ifdef UPDOWN_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  // Reference: count and number of enabled cycles since the last step, as plain integers.
  int MOD [2] = '{64, 10};
  int PRE [2] = '{1, 3};
  int m_cnt [2];
  int m_ph  [2];
  int m_tick[2];
  int m_tc  [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_ph[i] = 0; m_tick[i] = 0; m_tc[i] = 0;
    end
  endtask

  task automatic model_edge();
    int nxt;
    for (int i = 0; i < 2; i++) begin
      m_tick[i] = 0;
      m_tc[i]   = 0;
      if (clear) begin
        m_cnt[i] = 0;
        m_ph[i]  = 0;
      end else if (load) begin
        m_cnt[i] = (int'(load_val) < MOD[i]) ? int'(load_val) : MOD[i] - 1;
        m_ph[i]  = 0;
      end else if (en) begin
        m_ph[i]++;
        if (m_ph[i] == PRE[i]) begin
          m_ph[i]   = 0;
          m_tick[i] = 1;
          nxt = m_cnt[i] + (up ? 1 : -1);
          if (nxt >= MOD[i] || nxt < 0) begin
            m_tc[i] = 1;
            nxt = SAT ? m_cnt[i] : (nxt + MOD[i]) % MOD[i];
          end
          m_cnt[i] = nxt;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("a_count", 32'(if_a.count_o), m_cnt[0]);
    check("a_tick",  32'(if_a.tick_o),  m_tick[0]);
    check("a_tc",    32'(if_a.tc_o),    m_tc[0]);
    check("b_count", 32'(if_b.count_o), m_cnt[1]);
    check("b_tick",  32'(if_b.tick_o),  m_tick[1]);
    check("b_tc",    32'(if_b.tc_o),    m_tc[1]);
    if (if_a.tc_o === 1'b1) check("a_tc_implies_tick", 32'(if_a.tick_o), 1);
    if (if_b.tc_o === 1'b1) check("b_tc_implies_tick", 32'(if_b.tick_o), 1);
  endtask

  task automatic do_edge();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic set_in(input logic e, input logic u, input logic c, input logic l, input logic [5:0] v);
    en = e; up = u; clear = c; load = l; load_val = v;
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 6'd0);
    model_reset();
    #2;
    check_all();

    // Count up from reset release: wrap 63->0 on dut_a.
    @(negedge clk);
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 6'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 70; k++) do_edge();

    // Fresh reset, then count down: dut_b reaches 9 with tc on its 3rd edge.
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) do_edge();
    check("b_first_down_step", 32'(if_b.count_o), 9);
    check("b_first_down_tc",   32'(if_b.tc_o), 1);
    for (int k = 0; k < 12; k++) do_edge();

    // Load in range, then out of range (clamps).
    set_in(1'b1, 1'b1, 1'b0, 1'b1, 6'd7);
    do_edge();
    check("b_load7", 32'(if_b.count_o), 7);
    set_in(1'b1, 1'b1, 1'b0, 1'b1, 6'd12);
    do_edge();
    check("b_load12_clamp", 32'(if_b.count_o), 9);
    check("a_load12", 32'(if_a.count_o), 12);
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 6'd0);
    for (int k = 0; k < 7; k++) do_edge();

    // Clear and load together with enable: clear wins, no step.
    set_in(1'b1, 1'b1, 1'b1, 1'b1, 6'd5);
    do_edge();
    check("b_clear_wins", 32'(if_b.count_o), 0);
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 6'd0);
    for (int k = 0; k < 6; k++) do_edge();

    // Enable gaps: prescaler holds while en=0.
    for (int k = 0; k < 12; k++) begin
      en = (k % 3) != 1;
      do_edge();
    end

    // Bound behaviour from 8 counting up.
    set_in(1'b1, 1'b1, 1'b0, 1'b1, 6'd8);
    do_edge();
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 6'd0);
    for (int k = 0; k < 12; k++) do_edge();

    // Asynchronous reset mid-prescale, observed before the next edge.
    en = 1'b1;
    do_edge();
    rst_n = 1'b0;
    model_reset();
    #2;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) do_edge();

    // Random traffic.
    for (int k = 0; k < 600; k++) begin
      en       = ($urandom % 4) != 0;
      if (($urandom % 8) == 0) up = ~up;
      clear    = ($urandom % 32) == 0;
      load     = ($urandom % 16) == 0;
      load_val = 6'($urandom % 64);
      do_edge();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/updown_counter.md
# updown_counter

Parametrised up/down counter with modulus, synchronous load/clear, enable prescaler and terminal-count strobe. Next generation of the team's free-running LED counter. Sits between the board clock/reset and the LED/display drivers, or feeds other blocks as a tick/event source. All outputs are registered.

## Interface
- WIDTH, 6, counter width in bits
- MODULUS, 64, count range 0..MODULUS-1; legal range 2..2^WIDTH
- PRESCALE, 1, number of enabled cycles per count step; legal range ≥1; 1 means step on every enabled cycle

- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- en  in  1  count enable; gates both the prescaler and the count
- up  in  1  direction: 1 counts up, 0 counts down
- clear  in  1  synchronous clear to 0
- load  in  1  synchronous load of load_val
- load_val  in  WIDTH  value to load
- count  out  WIDTH  current count
- tick  out  1  one-cycle strobe, high in the cycle after each count step
- tc  out  1  one-cycle strobe, high in the cycle after each wrap or bound hit

## Operation
- Reset (reset=0, asynchronous): count=0, prescaler=0, tick=0, tc=0; held while reset is low.
- Per-edge priority: clear > load > step > hold.
- clear=1: count←0; prescaler←0; tick=0; tc=0.
- load=1 (clear=0): count←load_val if load_val<MODULUS, otherwise MODULUS-1; prescaler←0; tick=0; tc=0.
- Prescaler: internal counter of width max(1, clog2(PRESCALE)). When en=1 it increments; when it reaches PRESCALE-1 it returns to 0 and a step occurs. When en=0 it holds its value.
- Step, up=1: count<MODULUS-1 → count+1; count=MODULUS-1 → 0 and tc=1.
- Step, up=0: count>0 → count-1; count=0 → MODULUS-1 and tc=1.
- Every step sets tick=1 for one cycle. With no step, tick=0 and tc=0.
- A change of up between steps does not reset the prescaler. The next step uses the value of up sampled on the stepping edge.
- All arithmetic is WIDTH bits wide with explicit compare against MODULUS-1. count never leaves 0..MODULUS-1.

## Timing
- Latency: one edge. count, tick and tc change on the same edge, so tick and tc are high while count shows the new value.
- With en held high, the first step after reset release is on the PRESCALE-th rising edge. After that, one step every PRESCALE edges.
- If en and clear, or en and load, are high on the same edge, clear or load wins and no step occurs.
- Reset asserted mid-prescale: state clears immediately. There is no partial-step memory.
- tc is never high without tick also being high.

## Configuration
- UPDOWN_COUNTER_SATURATE_EN defined: the counter saturates instead of wrapping.
  - Up at MODULUS-1 holds MODULUS-1; down at 0 holds 0.
  - tc pulses on each step attempted at the bound, so it repeats every PRESCALE enabled cycles while at the bound.
  - tick still pulses on those attempts.
- Macro undefined (default): modulo wrap as described in Operation.

## Test plan
- Default parameters, en=1, up=1 after reset release → count 0,1,…,63,0. tick high every cycle. tc high only in the cycle count shows 0 after 63.
- MODULUS=10, PRESCALE=3, en=1, up=0 → count 0→9 on edge 3 with tc=1, then 8 on edge 6. tick high on edges 3,6,9…
- load=1, load_val=7 (MODULUS=10) → count=7 next cycle, prescaler reset. Then load_val=12 → count=9 (clamped), tick=0, tc=0.
- clear=1 and load=1 together with en=1 → count=0, tick=0, tc=0. Deassert both → next step after PRESCALE edges.
- en toggled 1,0,1 with PRESCALE=3 → prescaler holds during en=0. The step lands on the 3rd enabled edge. Reset pulsed low mid-sequence → count=0 asynchronously, before the next clock edge.
- UPDOWN_COUNTER_SATURATE_EN defined, MODULUS=10, up=1 from 8 → 9 then holds 9. tc=1 on each subsequent step attempt; count never reads 0.
